// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : psum_accumulator
// Brief    : Accumulates signed adder-tree partial sums over an in_last-framed
//            vector and hands the result downstream over valid/ready.
//            Optional clamping on overflow: define PSUM_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module psum_accumulator #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    logic                   beat_w;
    logic [ACC_WIDTH-1:0]   first_w;
    logic [ACC_WIDTH-1:0]   add_w;
    logic [CNT_WIDTH-1:0]   count_inc_w;

    // in_ready is gated by rst so nothing is accepted during the reset cycle
    assign in_ready    = ~rst & (state_q != S_DONE);
    assign beat_w      = in_valid & in_ready;
    assign first_w     = ACC_WIDTH'($signed(in_data));
    assign count_inc_w = (count_q == {CNT_WIDTH{1'b1}}) ? count_q
                                                         : count_q + CNT_WIDTH'(1);

`ifdef PSUM_SATURATE_EN
    localparam int                   EXT_W   = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [EXT_W-1:0] sum_w;
    logic             add_ovf_w;
    logic             ovf_q;

    // One guard bit: the top two bits of the widened sum disagree on overflow
    assign sum_w     = {acc_q[ACC_WIDTH-1], acc_q} + EXT_W'($signed(in_data));
    assign add_ovf_w = sum_w[EXT_W-1] ^ sum_w[EXT_W-2];
    assign add_w     = add_ovf_w ? (sum_w[EXT_W-1] ? ACC_MIN : ACC_MAX)
                                 : sum_w[ACC_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (beat_w) begin
            if (state_q == S_IDLE) begin
                ovf_q <= 1'b0;
            end else if (add_ovf_w) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign out_ovf = ovf_q;
`else
    assign add_w   = acc_q + ACC_WIDTH'($signed(in_data));
    assign out_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (beat_w) begin
                    acc_d   = first_w;
                    count_d = CNT_WIDTH'(1);
                    state_d = in_last ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (beat_w) begin
                    acc_d   = add_w;
                    count_d = count_inc_w;
                    if (in_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Result registers are frozen here until the handshake completes
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_data  = acc_q;
    assign out_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_accumulator
// Brief    : Directed bench for psum_accumulator with a queue-based result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_accumulator;

    localparam int     IW   = 16;
    localparam int     AW   = 24;
    localparam int     CW   = 8;
    localparam longint AMAX = 64'sd8388607;
    localparam longint AMIN = -64'sd8388608;
    localparam longint AMOD = 64'sd16777216;
    localparam int     CMAX = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_ovf;

    psum_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Result model: whole-vector arithmetic on wide integers
    typedef struct {
        longint d;
        int     c;
        bit     o;
    } res_t;

    res_t   exp_q[$];
    longint m_acc;
    int     m_cnt;
    bit     m_ovf;
    bit     m_first = 1'b1;

    function automatic void model_beat(input longint b, input bit last);
        if (m_first) begin
            m_acc   = b;
            m_cnt   = 1;
            m_ovf   = 1'b0;
            m_first = 1'b0;
        end else begin
            m_acc = m_acc + b;
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
`ifdef PSUM_SATURATE_EN
            if (m_acc > AMAX) begin
                m_acc = AMAX;
                m_ovf = 1'b1;
            end else if (m_acc < AMIN) begin
                m_acc = AMIN;
                m_ovf = 1'b1;
            end
`else
            if (m_acc > AMAX) m_acc = m_acc - AMOD;
            else if (m_acc < AMIN) m_acc = m_acc + AMOD;
`endif
        end
        if (last) begin
            exp_q.push_back('{d: m_acc, c: m_cnt, o: m_ovf});
            m_first = 1'b1;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_first = 1'b1;
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) model_beat(longint'($signed(in_data)), in_last);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            #2;
            check("model_in_ready", in_ready, (!rst && exp_q.size() == 0));
            check("model_out_valid", out_valid, (exp_q.size() != 0));
            if (exp_q.size() != 0 && out_valid) begin
                check("model_out_data", $signed(out_data), exp_q[0].d);
                check("model_out_count", out_count, exp_q[0].c);
                check("model_out_ovf", out_ovf, exp_q[0].o);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_beat(input longint d, input bit last, output int waits);
        bit ok;
        in_valid = 1'b1;
        in_data  = IW'(d);
        in_last  = last;
        waits    = 0;
        forever begin
            ok = in_ready;
            tick();
            if (ok) break;
            waits++;
            if (waits > 50) begin
                total++;
                bad++;
                $display("FAIL beat_accept_timeout: got waits=%0d expected <=50", waits);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string name, input longint d, input int c, input bit o);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, $signed(out_data), d);
        check({name, "_count"}, out_count, c);
        check({name, "_ovf"}, out_ovf, o);
    endtask

    int w;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_count", out_count, 0);
        check("reset_out_ovf", out_ovf, 0);
        rst = 1'b0;
        tick();
        chk_en = 1'b1;

        // 1: 5, -3, 100 -> 102 one cycle after the last beat
        send_beat(5, 1'b0, w);
        send_beat(-3, 1'b0, w);
        send_beat(100, 1'b1, w);
        check("t1_latency_valid", out_valid, 1);
        check("t1_in_ready_done", in_ready, 0);
        check("t1_data", $signed(out_data), 102);
        check("t1_count", out_count, 3);
        check("t1_ovf", out_ovf, 0);
        tick();
        check("t1_valid_drop", out_valid, 0);
        check("t1_ready_back", in_ready, 1);

        // 2: single most-negative beat
        send_beat(-32768, 1'b1, w);
        check("t2_data_hex", out_data, 64'hFF8000);
        check("t2_count", out_count, 1);
        tick();

        // 3: backpressure with a beat held upstream during DONE
        send_beat(3, 1'b0, w);
        out_ready = 1'b0;
        send_beat(4, 1'b1, w);
        in_valid = 1'b1; in_data = 16'd9; in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_data", $signed(out_data), 7);
            check("t3_hold_count", out_count, 2);
            check("t3_hold_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        send_beat(9, 1'b1, w);
        check("t3_restart_delay", w, 1);
        wait_result("t3_next", 9, 1, 1'b0);
        tick();

        // 4: 257 x 32767 with random bubbles
        for (int i = 1; i <= 257; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_beat(32767, (i == 257), w);
        end
`ifdef PSUM_SATURATE_EN
        wait_result("t4_long_pos", 8388607, 255, 1'b1);
`else
        wait_result("t4_long_pos", -8356097, 255, 1'b0);
`endif
        tick();

        // 5: reset mid-vector discards the partial result
        send_beat(10, 1'b0, w);
        send_beat(20, 1'b0, w);
        rst = 1'b1;
        #1;
        check("t5_rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t5_no_result", out_valid, 0);
            tick();
        end
        send_beat(1, 1'b0, w);
        send_beat(1, 1'b1, w);
        wait_result("t5_after_rst", 2, 2, 1'b0);
        tick();

        // 6: 257 x -32768, then a short vector clears the sticky flag
        for (int i = 1; i <= 257; i++) send_beat(-32768, (i == 257), w);
`ifdef PSUM_SATURATE_EN
        wait_result("t6_long_neg", -8388608, 255, 1'b1);
`else
        wait_result("t6_long_neg", 8355840, 255, 1'b0);
`endif
        tick();
        send_beat(4, 1'b1, w);
        wait_result("t6_after", 4, 1, 1'b0);

        repeat (4) tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
